// File: rtl/sata_identify_generator_pkg.sv
// Shared IDENTIFY DEVICE layout: dword offsets, signature, FSM state type and
// content helpers used by the device-side frame generator.
package sata_identify_generator_pkg;

    localparam int IDENTIFY_DWORDS  = 128;

    localparam int WORD0_OFFSET     = 0;
    localparam int CAP49_OFFSET     = 24;
    localparam int LBA28_OFFSET     = 30;
    localparam int SATA_CAP_OFFSET  = 38;
    localparam int CMDSET83_OFFSET  = 41;
    localparam int CMDSET86_OFFSET  = 43;
    localparam int MAX_LBA_OFFSET   = 50;
    localparam int CHECKSUM_OFFSET  = 127;

    localparam logic [7:0]  IDENTIFY_SIG = 8'hA5;
    localparam logic [47:0] LBA28_MAX    = 48'h0000_0FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_ABORT = 2'd2
    } id_state_e;

    function automatic logic [7:0] byte_sum(input logic [31:0] d);
        return d[7:0] + d[15:8] + d[23:16] + d[31:24];
    endfunction

    // Word 2N sits in bits 15:0 of dword N, word 2N+1 in bits 31:16.
    function automatic logic [31:0] identify_dword(
        input int          idx,
        input logic [15:0] word0,
        input logic [2:0]  caps,
        input logic [47:0] lba,
        input logic [7:0]  sum
    );
        logic [31:0] d;
        logic [7:0]  cs;
        d  = 32'h0000_0000;
        cs = 8'h00 - (sum + IDENTIFY_SIG);
        case (idx)
            WORD0_OFFSET:       d = {16'h0000, word0};
            CAP49_OFFSET:       d[25] = 1'b1;
            LBA28_OFFSET:       d = (lba > LBA28_MAX) ? 32'h0FFF_FFFF : lba[31:0];
            SATA_CAP_OFFSET:    d[3:1] = caps;
            CMDSET83_OFFSET:    d[26] = 1'b1;
            CMDSET86_OFFSET:    d[26] = 1'b1;
            MAX_LBA_OFFSET:     d = lba[31:0];
            MAX_LBA_OFFSET + 1: d = {16'h0000, lba[47:32]};
            CHECKSUM_OFFSET:    d = {cs, IDENTIFY_SIG, 16'h0000};
            default:            d = 32'h0000_0000;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sata_identify_generator.sv
// Device-side IDENTIFY DEVICE frame source: streams 128 dwords with a
// valid/ready handshake, supports abort, and appends the word-255 checksum.
module sata_identify_generator
    import sata_identify_generator_pkg::*;
#(
    parameter int          FIS_LEN   = IDENTIFY_DWORDS,
    parameter logic [15:0] WORD0_VAL = 16'h0040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  sata_caps,
    input  logic [47:0] max_lba,
    input  logic        abort,
    output logic [31:0] o_dat,
    output logic        o_val,
    output logic        o_eop,
    output logic        o_err,
    input  logic        o_rdy,
    output logic        busy,
    output logic        done
);

    localparam int             IW       = $clog2(FIS_LEN);
    localparam logic [IW-1:0]  LAST_IDX = IW'(FIS_LEN - 1);

    id_state_e     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [2:0]    caps_q, caps_d;
    logic [47:0]   lba_q, lba_d;
    logic [31:0]   o_dat_q, o_dat_d;
    logic          o_val_q, o_val_d;
    logic          o_eop_q, o_eop_d;
    logic          o_err_q, o_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          xfer_s;

    // Next-state logic; o_dat_d always carries the dword for idx_d so the
    // output beat is registered and holds naturally across stalls.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        caps_d  = caps_q;
        lba_d   = lba_q;
        o_dat_d = o_dat_q;
        o_val_d = o_val_q;
        o_eop_d = o_eop_q;
        o_err_d = o_err_q;
        done_d  = 1'b0;
        xfer_s  = o_val_q & o_rdy;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    caps_d  = sata_caps;
                    lba_d   = max_lba;
                    idx_d   = '0;
                    sum_d   = 8'h00;
                    o_dat_d = identify_dword(WORD0_OFFSET, WORD0_VAL, sata_caps, max_lba, 8'h00);
                    o_val_d = 1'b1;
                    o_eop_d = 1'b0;
                    o_err_d = 1'b0;
                end else begin
                    o_val_d = 1'b0;
                end
            end
            ST_SEND: begin
                // A final-beat transfer wins over a simultaneous abort.
                if (xfer_s && (idx_q == LAST_IDX)) begin
                    state_d = ST_IDLE;
                    o_dat_d = 32'h0000_0000;
                    o_val_d = 1'b0;
                    o_eop_d = 1'b0;
                    o_err_d = 1'b0;
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d = ST_ABORT;
                    o_dat_d = 32'h0000_0000;
                    o_val_d = 1'b1;
                    o_eop_d = 1'b1;
                    o_err_d = 1'b1;
                end else if (xfer_s) begin
                    if (int'(idx_q) < CHECKSUM_OFFSET) begin
                        sum_d = sum_q + byte_sum(o_dat_q);
                    end else begin
                        sum_d = sum_q;
                    end
                    idx_d   = idx_q + IW'(1);
                    o_dat_d = identify_dword(int'(idx_d), WORD0_VAL, caps_q, lba_q, sum_d);
                    o_eop_d = (idx_d == LAST_IDX);
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_ABORT: begin
                if (o_rdy) begin
                    state_d = ST_IDLE;
                    o_dat_d = 32'h0000_0000;
                    o_val_d = 1'b0;
                    o_eop_d = 1'b0;
                    o_err_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    o_val_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                o_val_d = 1'b0;
                o_eop_d = 1'b0;
                o_err_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sum_q   <= 8'h00;
            caps_q  <= 3'b000;
            lba_q   <= 48'h0000_0000_0000;
            o_dat_q <= 32'h0000_0000;
            o_val_q <= 1'b0;
            o_eop_q <= 1'b0;
            o_err_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            caps_q  <= caps_d;
            lba_q   <= lba_d;
            o_dat_q <= o_dat_d;
            o_val_q <= o_val_d;
            o_eop_q <= o_eop_d;
            o_err_q <= o_err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_dat = o_dat_q;
    assign o_val = o_val_q;
    assign o_eop = o_eop_q;
    assign o_err = o_err_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sata_identify_generator.sv
// Directed bench for the IDENTIFY frame generator: content, checksum, stalls,
// abort, reset mid-frame and start sequencing.
module tb_sata_identify_generator;

    logic        clk = 1'b0;
    logic        reset, start, abort, o_rdy;
    logic [2:0]  sata_caps;
    logic [47:0] max_lba;
    logic [31:0] o_dat;
    logic        o_val, o_eop, o_err, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] got_dat [128];
    logic        got_eop [128];
    logic        got_err [128];
    int          nbeats;
    logic [31:0] exp_dat [128];

    always #5 clk = ~clk;

    sata_identify_generator dut (
        .clk(clk), .reset(reset), .start(start), .sata_caps(sata_caps),
        .max_lba(max_lba), .abort(abort), .o_dat(o_dat), .o_val(o_val),
        .o_eop(o_eop), .o_err(o_err), .o_rdy(o_rdy), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-frame reference built from the ATA field definitions.
    function automatic void build_model(input logic [2:0] caps, input logic [47:0] lba);
        logic [7:0] s;
        logic [7:0] cs;
        for (int i = 0; i < 128; i++) exp_dat[i] = 32'h0;
        exp_dat[0]  = 32'h0000_0040;
        exp_dat[24] = 32'h0200_0000;
        exp_dat[30] = (lba > 48'h0000_0FFF_FFFF) ? 32'h0FFF_FFFF : lba[31:0];
        exp_dat[38] = {28'h0, caps, 1'b0};
        exp_dat[41] = 32'h0400_0000;
        exp_dat[43] = 32'h0400_0000;
        exp_dat[50] = lba[31:0];
        exp_dat[51] = {16'h0000, lba[47:32]};
        s = 8'h00;
        for (int i = 0; i < 127; i++)
            s = s + exp_dat[i][7:0] + exp_dat[i][15:8] + exp_dat[i][23:16] + exp_dat[i][31:24];
        cs = 8'h00 - s - 8'hA5;
        exp_dat[127] = {cs, 8'hA5, 16'h0000};
    endfunction

    task automatic start_frame(input logic [2:0] c, input logic [47:0] l);
        start     = 1'b1;
        sata_caps = c;
        max_lba   = l;
        build_model(c, l);
        @(negedge clk);
        start = 1'b0;
        chk("first_val", o_val, 1);
        chk("busy_on", busy, 1);
    endtask

    // Sink loop: rdy_mode 0 = always ready, 1 = ~30% ready.
    task automatic collect(input int rdy_mode, input int abort_at, input bit abort_on_last);
        int          stall_left = 0;
        bit          fin = 1'b0, pstall = 1'b0, aborted = 1'b0;
        bit          rdy;
        logic [31:0] pd;
        logic        pe, pr;
        nbeats = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (pstall) begin
                chk("stall_dat", o_dat, pd);
                chk("stall_eop", o_eop, pe);
                chk("stall_err", o_err, pr);
            end
            abort = 1'b0;
            rdy   = (rdy_mode == 1) ? ($urandom_range(99) < 30) : 1'b1;
            if (abort_at >= 0 && nbeats == abort_at && o_val && !aborted) begin
                abort      = 1'b1;
                aborted    = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            if (abort_on_last && nbeats == 127 && o_val) abort = 1'b1;
            o_rdy = rdy;
            if (o_val && rdy && nbeats < 128) begin
                got_dat[nbeats] = o_dat;
                got_eop[nbeats] = o_eop;
                got_err[nbeats] = o_err;
                nbeats++;
                if (o_eop) fin = 1'b1;
            end
            pstall = o_val && !rdy && !abort;
            pd = o_dat; pe = o_eop; pr = o_err;
            @(negedge clk);
        end
        abort = 1'b0;
        o_rdy = 1'b1;
        chk("frame_end_seen", fin, 1);
    endtask

    task automatic check_frame(input string tag);
        logic [7:0] s;
        s = 8'h00;
        chk({tag, "_beats"}, nbeats, 128);
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("%s_dw%0d", tag, i), got_dat[i], exp_dat[i]);
            chk($sformatf("%s_eop%0d", tag, i), got_eop[i], (i == 127));
            chk($sformatf("%s_err%0d", tag, i), got_err[i], 0);
            s = s + got_dat[i][7:0] + got_dat[i][15:8] + got_dat[i][23:16] + got_dat[i][31:24];
        end
        chk({tag, "_bytesum"}, s, 8'h00);
    endtask

    task automatic check_done_pulse(input string tag);
        chk({tag, "_done_hi"}, done, 1);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_val_lo"}, o_val, 0);
        @(negedge clk);
        chk({tag, "_done_lo"}, done, 0);
        chk({tag, "_val_still_lo"}, o_val, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; o_rdy = 1'b1;
        sata_caps = 3'b000; max_lba = 48'h0;
        repeat (3) @(negedge clk);
        chk("rst_val", o_val, 0);
        chk("rst_eop", o_eop, 0);
        chk("rst_err", o_err, 0);
        chk("rst_dat", o_dat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Frame 1: full caps, large LBA, always ready.
        start_frame(3'b111, 48'hABCD_1234_5678);
        collect(0, -1, 1'b0);
        check_done_pulse("f1");
        check_frame("f1");
        chk("f1_dw38", got_dat[38], 32'h0000_000E);
        chk("f1_dw50", got_dat[50], 32'h1234_5678);
        chk("f1_dw51", got_dat[51], 32'h0000_ABCD);
        chk("f1_dw30", got_dat[30], 32'h0FFF_FFFF);

        // Frame 2: LBA below the 28-bit limit.
        start_frame(3'b010, 48'h0000_0100_0000);
        collect(0, -1, 1'b0);
        check_done_pulse("f2");
        check_frame("f2");
        chk("f2_dw30", got_dat[30], 32'h0100_0000);
        chk("f2_dw38", got_dat[38], 32'h0000_0004);
        chk("f2_sig", got_dat[127][23:16], 8'hA5);

        // Frame 3: random back-pressure, then start on the done cycle.
        start_frame(3'b111, 48'hABCD_1234_5678);
        collect(1, -1, 1'b0);
        check_frame("f3");
        chk("f3_done_hi", done, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_val", o_val, 1);
        chk("b2b_dw0", o_dat, 32'h0000_0040);
        collect(0, -1, 1'b0);
        check_done_pulse("b2b");
        check_frame("b2b");

        // Abort at idx 60 with three stalled cycles.
        start_frame(3'b001, 48'h0000_0000_1000);
        collect(0, 60, 1'b0);
        chk("ab_beats", nbeats, 61);
        chk("ab_dat", got_dat[60], 32'h0);
        chk("ab_eop", got_eop[60], 1);
        chk("ab_err", got_err[60], 1);
        chk("ab_eop59", got_eop[59], 0);
        chk("ab_dw50", got_dat[50], 32'h0000_1000);
        check_done_pulse("ab");

        // Abort coinciding with the final-beat transfer.
        start_frame(3'b100, 48'h0000_0000_0042);
        collect(0, -1, 1'b1);
        check_done_pulse("ablast");
        check_frame("ablast");

        // Start while busy is dropped.
        start_frame(3'b011, 48'h0001_0000_0000);
        o_rdy = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sb_busy", busy, 1);
        collect(0, -1, 1'b0);
        check_done_pulse("sb");
        check_frame("sb");
        @(negedge clk);
        chk("sb_no_second", o_val, 0);

        // Reset asserted at idx 10.
        start_frame(3'b111, 48'h0000_0000_0200);
        o_rdy = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_val_before", o_val, 1);
        #2 reset = 1'b0;
        #1;
        chk("mr_val", o_val, 0);
        chk("mr_eop", o_eop, 0);
        chk("mr_dat", o_dat, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_idle_val", o_val, 0);
        chk("mr_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
